fwperiph_dma_dbg_trace: RTL and testbench
=========================================

Name: fwperiph_dma_dbg_trace

Overview:
- Trace-capture end of the DMA debug tap interface; takes the same signal set the DMA engine drives into its debug hook.
- Timestamps each cycle that has an event and stores it in an on-chip FIFO.
- The FIFO drains over a valid/ready read port to a debug bridge or to software.
- Instantiated beside the DMA engine in place of the debug hook when trace is enabled.

Parameters:
- ch_count, 1, number of DMA channels (1..32). Used only to flag out-of-range ch_sel.
- depth, 16, FIFO entries. Power of two, >= 2.
- ts_width, 16, timestamp counter width (8..32).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- adr  in  32  DMA register address (tap side)
- dat_w  in  32  DMA register write data
- we  in  1  DMA register write strobe
- ch_sel  in  5  channel selected by the write
- dma_busy  in  1  engine busy level
- dma_done_all  in  1  all-channels-done level
- en  in  1  capture enable. Events are ignored while low.
- clr  in  1  synchronous flush: empties the FIFO and zeroes drop_cnt and the timestamp
- rd_valid  out  1  FIFO head valid
- rd_ready  in  1  consumer accepts head
- rd_data  out  74+ts_width  head entry
- level  out  $clog2(depth)+1  entries held
- drop_cnt  out  16  events lost to a full FIFO, saturating
- ovf  out  1  sticky; set on the first drop, cleared by clr

Behaviour:
- Reset values: FIFO empty, rd_valid=0, rd_data=0, level=0, drop_cnt=0, ovf=0, timestamp=0, edge-detect registers=0.
- Timestamp: increments every cycle and wraps modulo 2^ts_width. clr loads 0.
- Edge detect: register dma_busy and dma_done_all. Derive:
  - busy_rise = busy & ~busy_q
  - busy_fall = ~busy & busy_q
  - done_rise = done & ~done_q
- Edge registers update even when en=0, so enabling capture never produces a false edge.
- Event cycle: en & (we | busy_rise | busy_fall | done_rise). At most one entry is pushed per cycle.
- Entry field order, MSB to LSB: {bad_ch, we, busy_rise, busy_fall, done_rise, ch_sel[4:0], ts, adr, dat_w}.
  - bad_ch = we & (ch_sel >= ch_count).
  - When we=0, the adr and dat_w fields are 0.
- Push latency: an event in cycle N is visible at the head in cycle N+1 if the FIFO was empty. rd_data is registered from the FIFO head.
- Read handshake:
  - The head is popped on rd_valid & rd_ready.
  - rd_data and rd_valid are stable while rd_valid=1 and rd_ready=0.
  - rd_ready while empty has no effect.
- Full FIFO:
  - Event with no pop in the same cycle: entry dropped, drop_cnt increments (saturates at 16'hFFFF), ovf set.
  - Push and pop in the same cycle: the push is accepted and level is unchanged.
- Empty FIFO with push and rd_ready in the same cycle: the push is accepted and the new entry is not popped that cycle. There is no fall-through.
- level = entries held. It updates on the cycle after push/pop and never exceeds depth.
- clr priority: clr overrides push and pop in the same cycle. The next cycle has level=0, rd_valid=0, drop_cnt=0, ovf=0, ts=0.
- Reset mid-operation: all contents are lost and outputs return to reset values immediately (asynchronous).
- Pointer arithmetic: rd/wr pointers are $clog2(depth)+1 bits wide. The MSB disambiguates full from empty. Pointers wrap naturally.

Decomposition:
- Package fwperiph_dma_dbg_pkg: event-flag bit-position constants, the entry field offsets, and a function entry_width(ts_width).
- One sub-module, fwperiph_dma_dbg_fifo: a synchronous FIFO with parameters width and depth. It has push/pop, full/empty, level and flush, and a registered head output.
- The top level holds the edge detect, timestamp, entry packing and drop counter.

Test Plan:
- Write path: en=1, one we pulse with adr=0x10, dat_w=0xDEADBEEF, ch_sel=0, with ts=5 at that cycle. Required: rd_valid on the next cycle, rd_data flags={0,1,0,0,0}, ts=5, adr/dat match. rd_ready pops it and level returns to 0.
- Status edges: dma_busy 0->1 at ts=3 and 1->0 at ts=9, then dma_done_all 0->1 at ts=9. Required: two entries, (busy_rise, ts=3) and (busy_fall|done_rise, ts=9).
- Overflow: depth=16, 20 we pulses with rd_ready=0. Required: level=16, drop_cnt=4, ovf=1. The first 16 entries drain in order.
- Full with simultaneous pop: a push and rd_ready in the same cycle while full. Required: level stays 16 and drop_cnt is unchanged.
- Controls: an event with en=0 is not captured. ch_sel=3 with ch_count=2 sets bad_ch=1. clr asserted with a push pending gives level=0 and drop_cnt=0 next cycle.
- Async reset: assert reset mid-drain. Required: rd_valid=0 and level=0 without waiting for a clock edge, and normal capture after release.

Source files
------------

// File: rtl/fwperiph_dma_dbg_pkg.sv
// Shared definitions for the DMA debug trace capture block: event flag
// positions, entry field offsets and the entry width helper.
package fwperiph_dma_dbg_pkg;

    // Bit positions of the event flags inside the 5-bit flag field.
    localparam int FLAG_DONE_RISE = 0;
    localparam int FLAG_BUSY_FALL = 1;
    localparam int FLAG_BUSY_RISE = 2;
    localparam int FLAG_WE        = 3;
    localparam int FLAG_BAD_CH    = 4;
    localparam int FLAG_COUNT     = 5;

    // Fixed-width fields of a trace entry.
    localparam int CH_WIDTH  = 5;
    localparam int ADR_WIDTH = 32;
    localparam int DAT_WIDTH = 32;

    // Entry layout, LSB upwards: dat_w, adr, ts, ch_sel, flags.
    localparam int OFF_DAT = 0;
    localparam int OFF_ADR = OFF_DAT + DAT_WIDTH;
    localparam int OFF_TS  = OFF_ADR + ADR_WIDTH;

    // Flag field as a packed struct, MSB first.
    typedef struct packed {
        logic bad_ch;
        logic we;
        logic busy_rise;
        logic busy_fall;
        logic done_rise;
    } trace_flags_t;

    function automatic int off_ch(input int ts_w);
        return OFF_TS + ts_w;
    endfunction

    function automatic int off_flags(input int ts_w);
        return off_ch(ts_w) + CH_WIDTH;
    endfunction

    function automatic int entry_width(input int ts_w);
        return off_flags(ts_w) + FLAG_COUNT;
    endfunction

endpackage

// File: rtl/fwperiph_dma_dbg_fifo.sv
// Synchronous FIFO with a registered head output. Pointers carry one extra
// MSB so full and empty are distinguishable; a write into an empty FIFO is
// visible at the head on the next cycle and is never popped in the same cycle.
module fwperiph_dma_dbg_fifo #(
    parameter int width = 8,
    parameter int depth = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [width-1:0]         din,
    input  logic                     pop,
    output logic [width-1:0]         dout,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(depth):0]   level
);

    localparam int AW = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_ptr_nxt;
    logic [AW:0]      rd_ptr_nxt;
    logic             empty;
    logic             do_push;
    logic             do_pop;
    logic [width-1:0] head_nxt;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign valid   = ~empty;
    assign level   = wr_ptr - rd_ptr;
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    // Next pointers and the value the head register will hold after this edge.
    always_comb begin
        wr_ptr_nxt = do_push ? wr_ptr + 1'b1 : wr_ptr;
        rd_ptr_nxt = do_pop  ? rd_ptr + 1'b1 : rd_ptr;
        head_nxt   = mem[rd_ptr_nxt[AW-1:0]];
        // The entry being written right now becomes the head: bypass the array.
        if (do_push && (wr_ptr[AW-1:0] == rd_ptr_nxt[AW-1:0])) begin
            head_nxt = din;
        end
        if (wr_ptr_nxt == rd_ptr_nxt) begin
            head_nxt = '0;
        end
    end

    // Pointer and head register update; flush empties the FIFO.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            dout   <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            dout   <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            dout   <= head_nxt;
        end
    end

    // Storage array write; contents need no reset since pointers gate them.
    always_ff @(posedge clock) begin
        if (do_push && !flush) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/fwperiph_dma_dbg_trace.sv
// DMA debug trace capture: edge-detects the engine status levels,
// timestamps every event cycle and queues one packed entry per event cycle
// into a FIFO drained over a valid/ready port. Events lost to a full FIFO
// are counted in a saturating counter and flagged in a sticky overflow bit.
module fwperiph_dma_dbg_trace
    import fwperiph_dma_dbg_pkg::*;
#(
    parameter int ch_count = 1,
    parameter int depth    = 16,
    parameter int ts_width = 16
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [31:0]                        adr,
    input  logic [31:0]                        dat_w,
    input  logic                               we,
    input  logic [4:0]                         ch_sel,
    input  logic                               dma_busy,
    input  logic                               dma_done_all,
    input  logic                               en,
    input  logic                               clr,
    output logic                               rd_valid,
    input  logic                               rd_ready,
    output logic [entry_width(ts_width)-1:0]   rd_data,
    output logic [$clog2(depth):0]             level,
    output logic [15:0]                        drop_cnt,
    output logic                               ovf
);

    localparam int EW        = entry_width(ts_width);
    localparam int OFF_CH    = off_ch(ts_width);
    localparam int OFF_FLAGS = off_flags(ts_width);
    localparam logic [5:0] CH_LIMIT = 6'(ch_count);

    logic                busy_q;
    logic                done_q;
    logic [ts_width-1:0] ts;
    logic                busy_rise;
    logic                busy_fall;
    logic                done_rise;
    logic                bad_ch;
    logic                event_cyc;
    logic                pop;
    logic                full;
    logic                drop;
    trace_flags_t        flags;
    logic [EW-1:0]       entry;

    assign busy_rise = dma_busy & ~busy_q;
    assign busy_fall = ~dma_busy & busy_q;
    assign done_rise = dma_done_all & ~done_q;
    assign bad_ch    = we & ({1'b0, ch_sel} >= CH_LIMIT);
    assign event_cyc = en & (we | busy_rise | busy_fall | done_rise);
    assign pop       = rd_valid & rd_ready;
    assign drop      = event_cyc & full & ~pop;

    // Status level history; runs regardless of en so enabling never fakes an edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= dma_busy;
            done_q <= dma_done_all;
        end
    end

    // Free-running timestamp, wraps naturally, zeroed by clr.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ts <= '0;
        end else if (clr) begin
            ts <= '0;
        end else begin
            ts <= ts + 1'b1;
        end
    end

    // Pack the entry; address and data only carry meaning on a write.
    always_comb begin
        flags.bad_ch    = bad_ch;
        flags.we        = we;
        flags.busy_rise = busy_rise;
        flags.busy_fall = busy_fall;
        flags.done_rise = done_rise;
        entry = '0;
        entry[OFF_DAT +: DAT_WIDTH]     = we ? dat_w : 32'h0;
        entry[OFF_ADR +: ADR_WIDTH]     = we ? adr : 32'h0;
        entry[OFF_TS +: ts_width]       = ts;
        entry[OFF_CH +: CH_WIDTH]       = ch_sel;
        entry[OFF_FLAGS +: FLAG_COUNT]  = flags;
    end

    // Saturating count of dropped events and the sticky overflow flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_cnt <= '0;
            ovf      <= 1'b0;
        end else if (clr) begin
            drop_cnt <= '0;
            ovf      <= 1'b0;
        end else if (drop) begin
            if (drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
            ovf <= 1'b1;
        end
    end

    fwperiph_dma_dbg_fifo #(
        .width (EW),
        .depth (depth)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (clr),
        .push  (event_cyc),
        .din   (entry),
        .pop   (pop),
        .dout  (rd_data),
        .valid (rd_valid),
        .full  (full),
        .level (level)
    );

endmodule

// File: tb/tb_fwperiph_dma_dbg_trace.sv
// Testbench for fwperiph_dma_dbg_trace: scenario tasks drive stimulus and
// push expected entries to a queue; a monitor pops and compares every entry
// the consumer accepts.
module tb_fwperiph_dma_dbg_trace;

    localparam int DEPTH = 16;
    localparam int TSW   = 16;
    localparam int EW    = 74 + TSW;

    logic          clock;
    logic          reset;
    logic [31:0]   adr;
    logic [31:0]   dat_w;
    logic          we;
    logic [4:0]    ch_sel;
    logic          dma_busy;
    logic          dma_done_all;
    logic          en;
    logic          clr;
    logic          rd_valid;
    logic          rd_ready;
    logic [EW-1:0] rd_data;
    logic [4:0]    level;
    logic [15:0]   drop_cnt;
    logic          ovf;

    int errors = 0;
    int checks = 0;
    logic [EW-1:0]  exp_q[$];
    logic [TSW-1:0] cur_ts;

    fwperiph_dma_dbg_trace #(
        .ch_count (2),
        .depth    (DEPTH),
        .ts_width (TSW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .adr          (adr),
        .dat_w        (dat_w),
        .we           (we),
        .ch_sel       (ch_sel),
        .dma_busy     (dma_busy),
        .dma_done_all (dma_done_all),
        .en           (en),
        .clr          (clr),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .level        (level),
        .drop_cnt     (drop_cnt),
        .ovf          (ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference timestamp: value the DUT should hold during the current cycle.
    always @(posedge clock or posedge reset) begin
        if (reset)    cur_ts <= '0;
        else if (clr) cur_ts <= '0;
        else          cur_ts <= cur_ts + 1'b1;
    end

    function automatic logic [EW-1:0] mk(input logic bad, input logic w, input logic br,
                                         input logic bf, input logic dr, input logic [4:0] ch,
                                         input logic [TSW-1:0] t, input logic [31:0] a,
                                         input logic [31:0] d);
        return {bad, w, br, bf, dr, ch, t, (w ? a : 32'h0), (w ? d : 32'h0)};
    endfunction

    // Scoreboard: compare every accepted head against the oldest expectation.
    always @(negedge clock) begin
        if (!reset && !clr && rd_valid && rd_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got %h, expected no entry", rd_data);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    errors++;
                    $display("FAIL sb_entry: got %h, expected %h", rd_data, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // Hold rd_ready until the FIFO empties or the bound expires.
    task automatic drain(input int bound);
        rd_ready = 1'b1;
        for (int i = 0; i < bound; i++) begin
            if (!rd_valid) break;
            tick();
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b, expected 0", rd_valid); end
        checks++; if (rd_data !== '0)    begin errors++; $display("FAIL reset_rd_data: got %h, expected 0", rd_data); end
        checks++; if (level !== 5'd0)    begin errors++; $display("FAIL reset_level: got %0d, expected 0", level); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d, expected 0", drop_cnt); end
        checks++; if (ovf !== 1'b0)      begin errors++; $display("FAIL reset_ovf: got %b, expected 0", ovf); end
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_write();
        logic [EW-1:0] e;
        do_clr();
        repeat (5) tick();
        adr = 32'h10; dat_w = 32'hDEADBEEF; ch_sel = 5'd0; we = 1'b1;
        e = {1'b0, 1'b1, 3'b000, 5'd0, 16'd5, 32'h10, 32'hDEADBEEF};
        exp_q.push_back(e);
        tick();
        we = 1'b0;
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL write_valid: got %b, expected 1", rd_valid); end
        checks++; if (rd_data !== e)     begin errors++; $display("FAIL write_data: got %h, expected %h", rd_data, e); end
        checks++; if (level !== 5'd1)    begin errors++; $display("FAIL write_level: got %0d, expected 1", level); end
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        checks++; if (level !== 5'd0)    begin errors++; $display("FAIL write_level_after_pop: got %0d, expected 0", level); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL write_valid_after_pop: got %b, expected 0", rd_valid); end
    endtask

    task automatic test_status_edges();
        do_clr();
        adr = 32'hAAAA5555; dat_w = 32'h12345678;
        repeat (3) tick();
        dma_busy = 1'b1;
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 16'd3, adr, dat_w));
        repeat (6) tick();
        dma_busy = 1'b0; dma_done_all = 1'b1;
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 16'd9, adr, dat_w));
        tick();
        checks++; if (level !== 5'd2) begin errors++; $display("FAIL edges_level: got %0d, expected 2", level); end
        dma_done_all = 1'b0;
        drain(10);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL edges_drain: %0d entries left, expected 0", exp_q.size()); end
    endtask

    task automatic test_overflow();
        do_clr();
        for (int i = 0; i < 20; i++) begin
            we = 1'b1; adr = 32'h100 + i; dat_w = 32'hC0DE0000 + i; ch_sel = 5'd1;
            if (i < DEPTH) exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, cur_ts, adr, dat_w));
            tick();
        end
        we = 1'b0;
        checks++; if (level !== 5'd16)     begin errors++; $display("FAIL ovf_level: got %0d, expected 16", level); end
        checks++; if (drop_cnt !== 16'd4)  begin errors++; $display("FAIL ovf_drop_cnt: got %0d, expected 4", drop_cnt); end
        checks++; if (ovf !== 1'b1)        begin errors++; $display("FAIL ovf_flag: got %b, expected 1", ovf); end
    endtask

    task automatic test_full_pop();
        we = 1'b1; adr = 32'h99; dat_w = 32'h9999; ch_sel = 5'd0; rd_ready = 1'b1;
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, cur_ts, adr, dat_w));
        tick();
        we = 1'b0; rd_ready = 1'b0;
        checks++; if (level !== 5'd16)    begin errors++; $display("FAIL fullpop_level: got %0d, expected 16", level); end
        checks++; if (drop_cnt !== 16'd4) begin errors++; $display("FAIL fullpop_drop_cnt: got %0d, expected 4", drop_cnt); end
        drain(40);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL fullpop_drain: %0d entries left, expected 0", exp_q.size()); end
        checks++; if (level !== 5'd0)    begin errors++; $display("FAIL fullpop_level_end: got %0d, expected 0", level); end
        checks++; if (ovf !== 1'b1)      begin errors++; $display("FAIL fullpop_ovf_sticky: got %b, expected 1", ovf); end
    endtask

    task automatic test_clr();
        do_clr();
        for (int i = 0; i < 18; i++) begin
            we = 1'b1; adr = i; dat_w = i;
            tick();
        end
        checks++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL clr_pre_drop: got %0d, expected 2", drop_cnt); end
        clr = 1'b1; rd_ready = 1'b1;
        tick();
        clr = 1'b0; we = 1'b0; rd_ready = 1'b0;
        checks++; if (level !== 5'd0)     begin errors++; $display("FAIL clr_level: got %0d, expected 0", level); end
        checks++; if (rd_valid !== 1'b0)  begin errors++; $display("FAIL clr_valid: got %b, expected 0", rd_valid); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL clr_drop_cnt: got %0d, expected 0", drop_cnt); end
        checks++; if (ovf !== 1'b0)       begin errors++; $display("FAIL clr_ovf: got %b, expected 0", ovf); end
    endtask

    task automatic test_controls();
        do_clr();
        en = 1'b0; we = 1'b1; adr = 32'h5; dat_w = 32'h5;
        tick();
        we = 1'b0; dma_busy = 1'b1;
        tick();
        en = 1'b1;
        tick();
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL ctl_en_low: got level %0d, expected 0", level); end
        dma_busy = 1'b0;
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, cur_ts, adr, dat_w));
        tick();
        we = 1'b1; ch_sel = 5'd3; adr = 32'h33; dat_w = 32'h3333;
        exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, cur_ts, adr, dat_w));
        tick();
        ch_sel = 5'd1; adr = 32'h11; dat_w = 32'h1111;
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, cur_ts, adr, dat_w));
        tick();
        we = 1'b0; ch_sel = 5'd0;
        checks++; if (rd_data[EW-1] !== 1'b0) begin errors++; $display("FAIL ctl_head_bad_ch: got %b, expected 0", rd_data[EW-1]); end
        checks++; if (level !== 5'd3) begin errors++; $display("FAIL ctl_level: got %0d, expected 3", level); end
        drain(10);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ctl_drain: %0d entries left, expected 0", exp_q.size()); end
    endtask

    task automatic test_async_reset();
        do_clr();
        for (int i = 0; i < 4; i++) begin
            we = 1'b1; adr = 32'h200 + i; dat_w = 32'hBEEF0000 + i;
            exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, cur_ts, adr, dat_w));
            tick();
        end
        we = 1'b0; rd_ready = 1'b1;
        tick();
        #2;
        reset = 1'b1;
        #1;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b, expected 0", rd_valid); end
        checks++; if (level !== 5'd0)    begin errors++; $display("FAIL arst_level: got %0d, expected 0", level); end
        checks++; if (rd_data !== '0)    begin errors++; $display("FAIL arst_data: got %h, expected 0", rd_data); end
        exp_q.delete();
        rd_ready = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        we = 1'b1; adr = 32'h77; dat_w = 32'h7777;
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, cur_ts, adr, dat_w));
        tick();
        we = 1'b0;
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL arst_recapture: got %b, expected 1", rd_valid); end
        drain(10);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL arst_drain: %0d entries left, expected 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        do_clr();
        rd_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            we = 1'b1; adr = 32'h300 + i; dat_w = $urandom; ch_sel = 5'(i % 2);
            exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ch_sel, cur_ts, adr, dat_w));
            tick();
            if (level > 5'd1) begin
                checks++; errors++;
                $display("FAIL b2b_level: got %0d, expected at most 1", level);
            end
        end
        we = 1'b0;
        drain(10);
        checks++; if (exp_q.size() != 0)  begin errors++; $display("FAIL b2b_drain: %0d entries left, expected 0", exp_q.size()); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL b2b_drop_cnt: got %0d, expected 0", drop_cnt); end
    endtask

    initial begin
        reset = 1'b0; adr = '0; dat_w = '0; we = 1'b0; ch_sel = '0;
        dma_busy = 1'b0; dma_done_all = 1'b0; en = 1'b1; clr = 1'b0; rd_ready = 1'b0;
        #2;
        test_reset();
        test_write();
        test_status_edges();
        test_overflow();
        test_full_pop();
        test_clr();
        test_controls();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
